// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: 00.00-99.99 s BCD stopwatch with IDLE/RUN/PAUSE control.
// Optional lap-freeze button enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [15:0] bcd,
  output logic        en_dec_pt,
  output logic        running,
  output logic        wrap
);
  localparam int PW = $clog2(TICK_DIV);
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [NB-1:0] btn, s1, s2, prev, rise;
  logic [PW-1:0] pre, pre_n;
  logic [15:0] count, count_n;
  logic tick, wrap_n;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = (c && v[4*i+:4] == 4'd9) ? 4'd0 : v[4*i+:4] + {3'd0, c};
      c = c && v[4*i+:4] == 4'd9;
    end
    return r;
  endfunction
`ifdef STOPWATCH_LAP_EN
  assign btn = {lap, clear, start_stop};
`else
  assign btn = {clear, start_stop};
`endif
  assign rise = s2 & ~prev;
  assign tick = state == RUN && pre == PW'(TICK_DIV - 1);
  assign wrap_n = tick && count == 16'h9999 && !rise[1];
  assign running = state == RUN;
  assign en_dec_pt = state != IDLE;
  always_comb begin
    state_n = state;
    pre_n = pre;
    count_n = count;
    case (state)
      IDLE: state_n = rise[0] ? RUN : IDLE;
      RUN: begin
        pre_n = tick ? '0 : pre + 1'b1;
        count_n = tick ? bcd_inc(count) : count;
        state_n = rise[0] ? PAUSE : RUN;
      end
      PAUSE: state_n = rise[0] ? RUN : PAUSE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && rise[1]) state_n = IDLE;
    if (state_n == IDLE) begin
      pre_n = '0;
      count_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      count <= '0;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      wrap <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      prev <= s2;
      state <= state_n;
      pre <= pre_n;
      count <= count_n;
      wrap <= wrap_n;
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic frz;
  logic [15:0] cap;
  // capture uses the pre-increment count so a lap on a tick edge shows the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frz <= 1'b0;
      cap <= '0;
    end else if (state_n == IDLE) begin
      frz <= 1'b0;
    end else if (state == RUN && rise[2]) begin
      frz <= ~frz;
      if (!frz) cap <= count;
    end
  end
  assign bcd = frz ? cap : count;
`else
  assign bcd = count;
`endif
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller that produces the 16-bit BCD value and decimal-point enable consumed by the 4-digit multiplexed 7-segment driver.
- Implements a 00.00–99.99 s stopwatch: a prescaler, a 4-digit cascaded BCD counter, button synchronisation and edge detection, and an IDLE/RUN/PAUSE state machine.
- Sits between the board push-buttons and the display driver.

Parameters:
- TICK_DIV, 1000000, clk cycles per 0.01 s count (100 MHz clk); legal range ≥ 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- start_stop  input  1  raw push-button, asynchronous to clk, active-high
- clear  input  1  raw push-button, asynchronous to clk, active-high
- bcd  output  16  [15:12] tens of s, [11:8] s, [7:4] tenths, [3:0] hundredths; each nibble 0–9
- en_dec_pt  output  1  decimal-point enable, high in RUN and PAUSE, low in IDLE
- running  output  1  high only in state RUN
- wrap  output  1  one-cycle pulse when the count rolls 99.99 -> 00.00

Behaviour:
- Reset (async, rst=1): state IDLE, count 0000, prescaler 0, synchronisers and edge-detect registers 0. Outputs: bcd=16'h0000, en_dec_pt=0, running=0, wrap=0. Reset asserted mid-count aborts immediately with no final increment.
- Button path, per button: sync1 -> sync2 -> prev, all flops. rise = sync2 & ~prev.
  - A button high at clk edge k (first sampled into sync1) gives rise during cycle k+1..k+2.
  - State and count update at edge k+2.
  - A held button produces exactly one rise.
- FSM:
  - IDLE: count=0, prescaler=0. start_stop rise -> RUN.
  - RUN: prescaler increments each cycle. When the prescaler equals TICK_DIV-1 it returns to 0 and the count increments on the same edge. start_stop rise -> PAUSE. clear rise -> IDLE.
  - PAUSE: count and prescaler hold, so the partial tick resumes on restart. start_stop rise -> RUN. clear rise -> IDLE.
  - Entering IDLE from RUN or PAUSE zeroes count and prescaler on the transition edge.
- Simultaneous start_stop and clear rise: clear wins, next state IDLE. A clear rise while already in IDLE has no effect.
- Timing of first increment: the first count increment occurs TICK_DIV cycles after the edge that entered RUN from IDLE.
- BCD increment: nibble 0 increments. A nibble at 9 with incoming carry becomes 0 and carries to the next nibble.
  - 9999 + 1 -> 0000 with wrap=1 for exactly that one cycle; the FSM stays in RUN.
  - Count values are never non-BCD.
- A tick coinciding with a start_stop rise in RUN: the increment is applied, then the state becomes PAUSE.
- A tick coinciding with a clear rise: clear wins and count = 0.
- Output timing: bcd, running and en_dec_pt are registered, or driven directly from state and count registers. Either way they reflect the new value in the cycle after the updating edge, with no combinational path from the button inputs.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds port "lap  input  1", with the same synchroniser and rise path as the other buttons.
  - A lap rise in RUN toggles a freeze flag. When the flag sets, the current count is captured and bcd shows the captured value while the internal count keeps running. The next lap rise in RUN clears the flag and bcd shows the live count again.
  - Lap rise in IDLE or PAUSE is ignored.
  - The freeze flag is cleared by rst and by any transition into IDLE.
  - A lap rise in the same cycle as a start_stop rise: both act. The freeze toggles using the pre-increment capture, and the state goes to PAUSE.
- Undefined: no lap port, no capture register; bcd always equals the live count.

Test Plan:
1. Assert rst mid-RUN with count 0012, TICK_DIV=4 -> bcd=0000, running=0, en_dec_pt=0 immediately (async), held until rst drops.
2. TICK_DIV=4, pulse start_stop -> running=1 at edge k+2, first increment 4 cycles later. After 40 further cycles bcd=16'h0011 (11 ticks).
3. Preload to 0999 via ticks, run one tick -> bcd=16'h1000. From 9999, one more tick -> bcd=0000, wrap high exactly 1 cycle, running stays 1.
4. Pause at bcd=0005 with prescaler=2, then restart -> next increment after 2 cycles, bcd=0006. clear in PAUSE -> bcd=0000, en_dec_pt=0, IDLE.
5. start_stop and clear asserted in the same cycle while in RUN -> IDLE, bcd=0000, no PAUSE visited. start_stop held 100 cycles -> single toggle only.
6. (STOPWATCH_LAP_EN) lap at bcd=0020 -> bcd frozen at 0020 while internal count advances. Second lap after 8 ticks -> bcd=0028. clear while frozen -> flag cleared, bcd=0000.
